// File: rtl/vi_burst_ctrl.sv
// VI marker-pulse burst sequencer: divides clk into the o320 strobe, gates it into oVI
// with one blank slot per group, and runs counted or continuous bursts with graceful stop.
module vi_burst_ctrl #(
  parameter int DIV      = 4,
  parameter int SLOTS    = 40,
  parameter int GAP_SLOT = 39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iStart,
  input  logic       iStop,
  input  logic [7:0] iGroups,
  output logic       o320,
  output logic       oVI,
  output logic [5:0] oSlot,
  output logic       oGroupEnd,
  output logic       oBusy,
  output logic       oDone
);

  localparam int              DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(DIV - 1);
  localparam logic [5:0]      SLOT_LAST = 6'(SLOTS - 1);
  localparam logic [5:0]      GAP_IDX   = 6'(GAP_SLOT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          r_state, w_stateNext;
  logic [DW-1:0]   r_divCnt, w_divNext;
  logic            r_phase, w_phaseNext;
  logic [5:0]      r_slot, w_slotNext;
  logic [7:0]      r_grpCnt, w_grpCntNext;
  logic [7:0]      r_grpLim, w_grpLimNext;
  logic            w_busy, w_halfEnd, w_grpEnd, w_lastGrp, w_busyNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_divCnt <= '0;
      r_phase  <= 1'b0;
      r_slot   <= '0;
      r_grpCnt <= '0;
      r_grpLim <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_divCnt <= w_divNext;
      r_phase  <= w_phaseNext;
      r_slot   <= w_slotNext;
      r_grpCnt <= w_grpCntNext;
      r_grpLim <= w_grpLimNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_divNext    = r_divCnt;
    w_phaseNext  = r_phase;
    w_slotNext   = r_slot;
    w_grpCntNext = r_grpCnt;
    w_grpLimNext = r_grpLim;
    w_busy    = (r_state == RUN) || (r_state == DRAIN);
    w_halfEnd = w_busy && (r_divCnt == DIV_LAST);
    w_grpEnd  = w_halfEnd && !r_phase && (r_slot == SLOT_LAST);
    w_lastGrp = (r_grpLim != 8'd0) && (({1'b0, r_grpCnt} + 9'd1) == {1'b0, r_grpLim});
    case (r_state)
      IDLE: begin
        if (iStart && !iStop) begin
          w_stateNext  = RUN;
          w_grpLimNext = iGroups;
          w_divNext    = '0;
          w_phaseNext  = 1'b1;
          w_slotNext   = '0;
          w_grpCntNext = '0;
        end
      end
      RUN, DRAIN: begin
        // A slot is one high half followed by one low half; it advances as the low half ends.
        if (w_halfEnd) begin
          w_divNext   = '0;
          w_phaseNext = ~r_phase;
          if (!r_phase) w_slotNext = (r_slot == SLOT_LAST) ? 6'd0 : r_slot + 6'd1;
        end else begin
          w_divNext = r_divCnt + DW'(1);
        end
        if (w_grpEnd && (r_grpCnt != 8'hFF)) w_grpCntNext = r_grpCnt + 8'd1;
        if (w_grpEnd && ((r_state == DRAIN) || iStop || w_lastGrp)) w_stateNext = DONE;
        else if ((r_state == RUN) && iStop) w_stateNext = DRAIN;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    w_busyNext = (w_stateNext == RUN) || (w_stateNext == DRAIN);
  end

  // Outputs are decoded from next-state values so that every port is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o320      <= 1'b0;
      oVI       <= 1'b0;
      oSlot     <= '0;
      oGroupEnd <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      o320      <= w_busyNext && w_phaseNext;
      oVI       <= w_busyNext && w_phaseNext && (w_slotNext != GAP_IDX);
      oSlot     <= w_busyNext ? w_slotNext : 6'd0;
      oGroupEnd <= w_busyNext && !w_phaseNext && (w_divNext == DIV_LAST) && (w_slotNext == SLOT_LAST);
      oBusy     <= w_busyNext;
      oDone     <= (w_stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_vi_burst_ctrl.sv
// Bench for vi_burst_ctrl: default and small-parameter instances checked cycle by cycle
// against an arithmetic model of the burst (strobe phase, slot and length from cycle index).
module tb_vi_burst_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start  [2];
  logic       stop   [2];
  logic [7:0] groups [2];
  logic       s320   [2];
  logic       sVI    [2];
  logic [5:0] sSlot  [2];
  logic       sGE    [2];
  logic       sBusy  [2];
  logic       sDone  [2];

  int compared   = 0;
  int mismatched = 0;
  int pDiv   [2] = '{4, 1};
  int pSlots [2] = '{40, 4};
  int pGap   [2] = '{39, 0};

  vi_burst_ctrl #(.DIV(4), .SLOTS(40), .GAP_SLOT(39)) uDef (
    .clk(clk), .rst(rst), .iStart(start[0]), .iStop(stop[0]), .iGroups(groups[0]),
    .o320(s320[0]), .oVI(sVI[0]), .oSlot(sSlot[0]), .oGroupEnd(sGE[0]),
    .oBusy(sBusy[0]), .oDone(sDone[0])
  );

  vi_burst_ctrl #(.DIV(1), .SLOTS(4), .GAP_SLOT(0)) uSmall (
    .clk(clk), .rst(rst), .iStart(start[1]), .iStop(stop[1]), .iGroups(groups[1]),
    .o320(s320[1]), .oVI(sVI[1]), .oSlot(sSlot[1]), .oGroupEnd(sGE[1]),
    .oBusy(sBusy[1]), .oDone(sDone[1])
  );

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic checkAll(input int sel, input int k, input logic e320, input logic eVI,
                          input logic [5:0] eSlot, input logic eGE, input logic eBusy, input logic eDone);
    check($sformatf("d%0d.o320", sel), k, 8'(s320[sel]), 8'(e320));
    check($sformatf("d%0d.oVI", sel), k, 8'(sVI[sel]), 8'(eVI));
    check($sformatf("d%0d.oSlot", sel), k, 8'(sSlot[sel]), 8'(eSlot));
    check($sformatf("d%0d.oGroupEnd", sel), k, 8'(sGE[sel]), 8'(eGE));
    check($sformatf("d%0d.oBusy", sel), k, 8'(sBusy[sel]), 8'(eBusy));
    check($sformatf("d%0d.oDone", sel), k, 8'(sDone[sel]), 8'(eDone));
  endtask

  // Starts a burst and checks every cycle; abortK >= 0 returns early (mid-burst) after that cycle.
  task automatic runBurst(input int sel, input int grp, input int stopK, input bit noise, input int abortK);
    int per, len, k0, slotK;
    logic e320;
    per = pSlots[sel] * 2 * pDiv[sel];
    if (grp == 0 && stopK < 0) stopK = per - 1;
    len = (grp != 0) ? grp * per : 32'h3FFF_FFFF;
    if (stopK >= 0 && ((stopK / per) + 1) * per < len) len = ((stopK / per) + 1) * per;
    start[sel]  = 1'b1;
    stop[sel]   = 1'b0;
    groups[sel] = 8'(grp);
    for (int k = 0; k <= len + 1; k++) begin
      @(posedge clk);
      #1;
      if (k < len) begin
        k0    = k / pDiv[sel];
        slotK = (k / (2 * pDiv[sel])) % pSlots[sel];
        e320  = (k0 % 2) == 0;
        checkAll(sel, k, e320, e320 && (slotK != pGap[sel]), 6'(slotK), ((k + 1) % per) == 0, 1'b1, 1'b0);
      end else if (k == len) begin
        checkAll(sel, k, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
      end else begin
        checkAll(sel, k, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      end
      if (k == abortK) return;
      start[sel]  = noise ? (($urandom_range(0, 3) == 0) || (k == len)) : 1'b0;
      groups[sel] = 8'($urandom);
      stop[sel]   = (k == stopK);
    end
    start[sel] = 1'b0;
    stop[sel]  = 1'b0;
  endtask

  initial begin
    int g, s;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; stop[i] = 1'b0; groups[i] = 8'd0;
    end
    #2;
    checkAll(0, -1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    checkAll(1, -1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkAll(0, -2, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    end

    // Start and stop together in idle: stop wins, nothing runs.
    start[0] = 1'b1; stop[0] = 1'b1; groups[0] = 8'd1;
    repeat (3) begin
      @(posedge clk); #1;
      checkAll(0, -3, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    end
    start[0] = 1'b0; stop[0] = 1'b0;
    @(posedge clk); #1;
    checkAll(0, -4, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);

    runBurst(0, 1, -1, 1'b0, -1);
    runBurst(0, 3, -1, 1'b0, -1);
    runBurst(0, 0, 320 + 80 + $urandom_range(0, 7), 1'b0, -1);
    runBurst(0, 0, 319, 1'b0, -1);
    runBurst(0, 2, -1, 1'b1, -1);
    repeat (2) begin
      g = $urandom_range(1, 2);
      s = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, g * 320 - 1);
      runBurst(0, g, s, 1'($urandom_range(0, 1)), -1);
    end

    // Reset mid-burst: outputs clear between clock edges and no done pulse follows.
    runBurst(0, 2, -1, 1'b0, $urandom_range(100, 500));
    start[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkAll(0, -5, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      checkAll(0, -6, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    end

    runBurst(1, 2, -1, 1'b0, -1);
    repeat (8) begin
      g = $urandom_range(0, 5);
      s = ($urandom_range(0, 1) == 0 && g != 0) ? -1 : $urandom_range(0, 47);
      runBurst(1, g, s, 1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
